// File: rtl/mem_access_initiator.sv
// Load/store sequencer for the pseudo-MMU port: strobes, ready handshake,
// sub-word read-before-write and misalignment trapping.
module mem_access_initiator #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WAIT    = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  misalign_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    output logic [2:0]            mem_funct3_o,
    output logic                  mem_mrd_no,
    output logic                  mem_mwr_no,
    input  logic                  mem_rdy_i,
    input  logic [DATA_WIDTH-1:0] mem_rd_i
);

    localparam int CNT_W = (RD_WAIT < 1) ? 1 : $clog2(RD_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_FAULT
    } state_t;

    state_t             state, state_nxt;
    logic               we_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic               misalign_req;
    logic               rd_last;
    logic               subword_q;

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   misalign_req = 1'b0;
            2'b01:   misalign_req = addr_i[0];
            2'b10:   misalign_req = |addr_i[1:0];
            default: misalign_req = 1'b1;
        endcase
    end

    // Data is sampled on the ready cycle after RD_WAIT ready cycles have elapsed.
    assign rd_last   = (state == S_READ) && mem_rdy_i && (wait_cnt == CNT_W'(RD_WAIT));
    assign subword_q = we_q && (mem_funct3_o[1:0] != 2'b10);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, otherwise any path
    // that misses an assignment infers a latch.
    always_comb begin
        state_nxt  = state;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        misalign_o = 1'b0;
        mem_mrd_no = 1'b1;
        mem_mwr_no = 1'b1;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (req_i) begin
                    if (misalign_req)                             state_nxt = S_FAULT;
                    else if (!we_i || (funct3_i[1:0] != 2'b10))   state_nxt = S_READ;
                    else                                          state_nxt = S_WRITE;
                end
            end
            S_READ: begin
                mem_mrd_no = 1'b0;
                if (rd_last) state_nxt = subword_q ? S_WRITE : S_DONE;
            end
            S_WRITE: begin
                mem_mwr_no = 1'b0;
                if (mem_rdy_i) state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            S_FAULT: begin
                done_o     = 1'b1;
                misalign_o = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            we_q         <= 1'b0;
            mem_addr_o   <= '0;
            mem_wd_o     <= '0;
            mem_funct3_o <= '0;
            rdata_o      <= '0;
            wait_cnt     <= '0;
        end else begin
            if ((state == S_IDLE) && req_i) begin
                we_q         <= we_i;
                mem_addr_o   <= addr_i;
                mem_wd_o     <= wdata_i;
                mem_funct3_o <= funct3_i;
            end
            if (rd_last && !we_q) rdata_o <= mem_rd_i;
            // Counts ready cycles only; stalls hold the count.
            if (state != S_READ || rd_last) wait_cnt <= '0;
            else if (mem_rdy_i)             wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule
